imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and packs it into 32-bit little-endian instruction words. Writes each word to the instruction memory write port at consecutive word addresses. Holds the core (`core_rst`) in reset until the load finishes, so the program counter and fetch path start only once the program image is complete.

## Interface
- `ADDR_WIDTH`, default `INSTRUCTION_MEMORY_ADDRESS_WIDTH`: word-address width of the instruction memory write port.
- `WORD_WIDTH`, default `INSTRUCTION_WIDTH` (32): instruction word width; must be 32.

- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: byte on `in_data` is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `reload` in 1: restart a load; honoured in DONE only.
- `mem_w_en` out 1: one-cycle instruction memory write strobe.
- `mem_w_addr` out ADDR_WIDTH: word address of the write.
- `mem_w_data` out 32: instruction word to write.
- `core_rst` out 1: reset to PC, register file and data memory.
- `done` out 1: load complete.
- `overflow` out 1: sticky; the image exceeded `2**ADDR_WIDTH` words.
- `checksum` out 32: XOR of every assembled word.

## Operation
- Handshake: a byte transfers on a rising edge with `in_valid && in_ready`. `in_ready` is a combinational decode of state: 1 in LEN_LO, LEN_HI and DATA; 0 in DONE.
- Stream format:
  - Byte 0 and byte 1 are word count N (16-bit, little-endian).
  - 4·N data bytes follow. Each word is little-endian: the first byte goes to bits [7:0] and the fourth to bits [31:24].
- FSM states:
  - LEN_LO: accept the low byte of N, then go to LEN_HI.
  - LEN_HI: accept the high byte of N. If N==0, go to DONE; otherwise go to DATA.
  - DATA: bytes fill a 2-bit byte counter. On the 4th byte, issue a write and advance the word index. On the byte that completes word N−1, go to DONE.
  - DONE: idle. `reload`=1 clears the word index, byte counter, `checksum` and `overflow`, asserts `core_rst`, then goes to LEN_LO.
- Word index is 16 bits. `mem_w_addr` = word index[ADDR_WIDTH−1:0].
- Overflow: if word index ≥ `2**ADDR_WIDTH`, suppress `mem_w_en`, set `overflow` (sticky), and keep consuming bytes until N words are received. There is no wrap-around write.
- `checksum` ^= word for every assembled word, including suppressed ones.
- `reload` outside DONE is ignored. Stalls (`in_valid`=0) at any point freeze all state.

## Timing
- Reset values: state=LEN_LO, `in_ready`=1 (from the first cycle after reset), `mem_w_en`=0, `mem_w_addr`=0, `mem_w_data`=0, `core_rst`=1, `done`=0, `overflow`=0, `checksum`=0, counters=0.
- Write latency: `mem_w_en`, `mem_w_addr` and `mem_w_data` are registered. They are valid for exactly one cycle, starting the cycle after the handshake of the word's 4th byte.
- Back-to-back: one byte per cycle sustained. At most one write every 4 cycles.
- `done` rises in the same cycle as the final `mem_w_en`. `core_rst` falls one cycle later, so the last write lands before fetch starts.
- N==0: `done`=1 the cycle after the LEN_HI handshake, with no write.
- `reload` in DONE: the next cycle has `done`=0, `core_rst`=1 and `in_ready`=1.
- `rst` mid-load: all registers return to reset values on that edge. Memory contents already written are left as is; the partial image is not erased.

## Structure
- In `params_pkg`:
  - `loader_state_t` enum {LEN_LO, LEN_HI, DATA, DONE}.
  - `LOADER_COUNT_WIDTH = 16`.
- Sub-module `byte_word_packer`: byte counter plus 32-bit shift/assemble register. It outputs `word_valid` for one cycle and the word, and has a `clear` input. The FSM, address counter, overflow logic and checksum stay in `imem_loader`.
- `top` integration: `core_rst` ORs into the `rst` of PROGRAM_COUNTER, register_file and data_memory.

## Test plan
- Stream 02 00, then 93 00 50 00, 13 01 A0 00 with no stalls:
  - writes addr0=0x00500093 and addr1=0x00A00113;
  - `done`=1 with the 2nd write, `core_rst`=0 one cycle later;
  - `checksum`=0x00A00113^0x00500093=0x00F00180.
- Same stream with `in_valid` toggled 1-0-1-0: same writes, same data, spaced per accepted bytes. No write occurs between bytes.
- N=0 (00 00): no `mem_w_en`, `done`=1 one cycle after the 2nd byte, `checksum`=0.
- ADDR_WIDTH=2, N=5: writes to addr0..3 only; the 5th word is suppressed; `overflow`=1; `done`=1; `checksum` covers all 5 words.
- Pulse `rst` after 2 data bytes, then send a full 1-word image 01 00 EF BE AD DE: a single write of addr0=0xDEADBEEF.
- In DONE, pulse `reload` and load 1 word 0x00000013: `core_rst` re-asserts the next cycle, `checksum` restarts at 0x00000013, and the write goes to addr0.

Source files
------------

// File: rtl/params_pkg.sv
// params_pkg: shared constants and types for the instruction-memory loader.
//   INSTRUCTION_MEMORY_ADDRESS_WIDTH : default word-address width of the imem write port
//   INSTRUCTION_WIDTH                : instruction word width (32)
//   LOADER_COUNT_WIDTH               : width of the image word count and word index
//   loader_state_t                   : loader FSM state encoding
package params_pkg;

    localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 10;
    localparam int INSTRUCTION_WIDTH                = 32;
    localparam int LOADER_COUNT_WIDTH               = 16;

    typedef enum logic [1:0] {
        LEN_LO = 2'd0,
        LEN_HI = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// byte_word_packer: collects four stream bytes into one little-endian 32-bit word.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : restart packing at byte 0 (load restart)
//   byte_valid    : a byte is accepted this cycle
//   byte_data     : the accepted byte
//   word_valid    : one-cycle pulse in the cycle the 4th byte is accepted
//   word_data     : assembled word, meaningful while word_valid is high
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;

    // The 4th byte is not stored; it is combined directly so the word is
    // available in the same cycle as its final handshake.
    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word_data  = {byte_data, low_bytes};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (byte_valid) begin
            case (byte_cnt)
                2'd0:    low_bytes[7:0]   <= byte_data;
                2'd1:    low_bytes[15:8]  <= byte_data;
                2'd2:    low_bytes[23:16] <= byte_data;
                default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader writing a length-prefixed byte stream into the
// instruction memory while holding the core in reset.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_data    : incoming stream byte
//   in_ready            : byte accepted when in_valid && in_ready
//   reload              : restart a load (only acted on once the load is done)
//   mem_w_en/addr/data  : registered one-cycle instruction memory write
//   core_rst            : held high until one cycle after the final write
//   done                : load complete
//   overflow            : sticky, image longer than the memory
//   checksum            : XOR of every assembled word
//
// state  | meaning
// LEN_LO | waiting for low byte of word count
// LEN_HI | waiting for high byte of word count
// DATA   | receiving image bytes, writing each completed word
// DONE   | load finished, core released, waiting for reload
module imem_loader
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTRUCTION_MEMORY_ADDRESS_WIDTH,
    parameter int WORD_WIDTH = INSTRUCTION_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [WORD_WIDTH-1:0] mem_w_data,
    output logic                  core_rst,
    output logic                  done,
    output logic                  overflow,
    output logic [WORD_WIDTH-1:0] checksum
);

    loader_state_t                 state;
    logic [LOADER_COUNT_WIDTH-1:0] word_count;
    logic [LOADER_COUNT_WIDTH-1:0] word_idx;
    logic                          fire;
    logic                          do_reload;
    logic                          addr_oob;
    logic                          last_word;
    logic                          word_valid;
    logic [31:0]                   word_data;

    assign in_ready  = (state != DONE);
    assign fire      = in_valid && in_ready;
    assign do_reload = (state == DONE) && reload;
    // Index beyond the memory: word is still consumed and checksummed, but not written.
    assign addr_oob  = (32'(word_idx) >= (32'd1 << ADDR_WIDTH));
    assign last_word = (word_idx == word_count - 16'd1);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (do_reload),
        .byte_valid (fire && (state == DATA)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LEN_LO;
            word_count <= '0;
            word_idx   <= '0;
            mem_w_en   <= 1'b0;
            mem_w_addr <= '0;
            mem_w_data <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            checksum   <= '0;
        end else begin
            mem_w_en <= 1'b0;
            case (state)
                LEN_LO: begin
                    if (fire) begin
                        word_count[7:0] <= in_data;
                        state           <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (fire) begin
                        word_count[15:8] <= in_data;
                        if ({in_data, word_count[7:0]} == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        mem_w_en   <= !addr_oob;
                        mem_w_addr <= word_idx[ADDR_WIDTH-1:0];
                        mem_w_data <= word_data;
                        checksum   <= checksum ^ word_data;
                        word_idx   <= word_idx + 16'd1;
                        if (addr_oob) overflow <= 1'b1;
                        if (last_word) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        state      <= LEN_LO;
                        done       <= 1'b0;
                        core_rst   <= 1'b1;
                        word_count <= '0;
                        word_idx   <= '0;
                        checksum   <= '0;
                        overflow   <= 1'b0;
                    end else begin
                        // Released one cycle after done so the last write lands first.
                        core_rst <= 1'b0;
                    end
                end
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader with a 4-word memory (ADDR_WIDTH=2).
module tb_imem_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          reload;
    logic          mem_w_en;
    logic [AW-1:0] mem_w_addr;
    logic [31:0]   mem_w_data;
    logic          core_rst;
    logic          done;
    logic          overflow;
    logic [31:0]   checksum;

    int            checks   = 0;
    int            failures = 0;
    logic [7:0]    img[$];
    logic [39:0]   exp_q[$];
    logic [39:0]   exp_w;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .core_rst   (core_rst),
        .done       (done),
        .overflow   (overflow),
        .checksum   (checksum)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_w_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", mem_w_en, 0);
            end else begin
                exp_w = exp_q.pop_front();
                chk("w_addr", 64'(mem_w_addr), 64'(exp_w[39:32]));
                chk("w_data", mem_w_data, exp_w[31:0]);
            end
        end
    end

    task automatic begin_img(input logic [15:0] n);
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
    endtask

    task automatic add_word(input logic [31:0] w, input int idx);
        img.push_back(w[7:0]);
        img.push_back(w[15:8]);
        img.push_back(w[23:16]);
        img.push_back(w[31:24]);
        if (idx < (1 << AW)) exp_q.push_back({8'(idx), w});
    endtask

    // Ends on the falling edge one cycle after the last handshake.
    task automatic send_img(input bit stall, input bit rel_during);
        for (int i = 0; i < img.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = img[i];
            reload   = rel_during;
            @(posedge clk);
            if (stall && (i < img.size() - 1)) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic finish_chk(input bit wrote);
        chk("done_rise", done, 1);
        chk("core_rst_hold", core_rst, 1);
        chk("last_wen", mem_w_en, wrote);
        @(negedge clk);
        chk("core_rst_fall", core_rst, 0);
        chk("done_hold", done, 1);
        chk("in_ready_done", in_ready, 0);
    endtask

    task automatic reload_pulse();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
        chk("rl_done", done, 0);
        chk("rl_core_rst", core_rst, 1);
        chk("rl_in_ready", in_ready, 1);
        chk("rl_checksum", checksum, 0);
        chk("rl_overflow", overflow, 0);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_wen"}, mem_w_en, 0);
        chk({tag, "_waddr"}, 64'(mem_w_addr), 0);
        chk({tag, "_wdata"}, mem_w_data, 0);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_chk("rst");
        rst = 1'b0;
        @(negedge clk);
        reset_chk("post_rst");

        // Two-word image, no stalls.
        begin_img(16'd2);
        add_word(32'h0050_0093, 0);
        add_word(32'h00A0_0113, 1);
        send_img(1'b0, 1'b0);
        finish_chk(1'b1);
        chk("a_checksum", checksum, 32'h00F0_0180);
        chk("a_overflow", overflow, 0);

        // Same image with a stall after every byte.
        reload_pulse();
        begin_img(16'd2);
        add_word(32'h0050_0093, 0);
        add_word(32'h00A0_0113, 1);
        send_img(1'b1, 1'b0);
        finish_chk(1'b1);
        chk("b_checksum", checksum, 32'h00F0_0180);

        // Empty image.
        reload_pulse();
        begin_img(16'd0);
        send_img(1'b0, 1'b0);
        finish_chk(1'b0);
        chk("n0_checksum", checksum, 0);

        // Five words into a four-word memory.
        reload_pulse();
        begin_img(16'd5);
        add_word(32'h0000_0001, 0);
        add_word(32'h0000_0020, 1);
        add_word(32'h0000_0300, 2);
        add_word(32'h0000_4000, 3);
        add_word(32'h0005_0000, 4);
        send_img(1'b0, 1'b0);
        finish_chk(1'b0);
        chk("ov_overflow", overflow, 1);
        chk("ov_checksum", checksum, 32'h0005_4321);

        // Reset in the middle of a load, then a fresh image with reload
        // held high throughout (must be ignored outside DONE).
        reload_pulse();
        begin_img(16'd2);
        img.push_back(8'h11);
        img.push_back(8'h22);
        send_img(1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_chk("mid_rst");
        begin_img(16'd1);
        add_word(32'hDEAD_BEEF, 0);
        send_img(1'b0, 1'b1);
        finish_chk(1'b1);
        chk("rst_checksum", checksum, 32'hDEAD_BEEF);

        // Reload and load a single NOP.
        reload_pulse();
        begin_img(16'd1);
        add_word(32'h0000_0013, 0);
        send_img(1'b0, 1'b0);
        finish_chk(1'b1);
        chk("nop_checksum", checksum, 32'h0000_0013);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
